// File: rtl/xgriscv_mc_ctrl_if.sv
// Control/status bundle between the xgriscv multi-cycle sequencer and its datapath.
// The sequencer uses the master side; the datapath (or a bench) uses the slave side.
interface xgriscv_mc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             br_taken;
  logic             mem_ready;
  logic             ir_we;
  logic             ab_we;
  logic             alu_we;
  logic             mdr_we;
  logic             pc_we;
  logic [1:0]       pc_src;
  logic             rf_we;
  logic [1:0]       wd_sel;
  logic             mem_req;
  logic             mem_we;
  logic             addr_sel;
  logic             halted;
  logic [1:0]       halt_cause;
  logic [CNT_W-1:0] instret;
  logic [2:0]       state;

  modport master (
    input  opcode, br_taken, mem_ready,
    output ir_we, ab_we, alu_we, mdr_we, pc_we, pc_src, rf_we, wd_sel,
           mem_req, mem_we, addr_sel, halted, halt_cause, instret, state
  );

  modport slave (
    output opcode, br_taken, mem_ready,
    input  ir_we, ab_we, alu_we, mdr_we, pc_we, pc_src, rf_we, wd_sel,
           mem_req, mem_we, addr_sel, halted, halt_cause, instret, state
  );
endinterface

// File: rtl/xgriscv_mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the xgriscv RV32I datapath.
// Strobes are decoded from state and inputs; only state, counters and halt info are registered.
module xgriscv_mc_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  xgriscv_mc_ctrl_if.master bus
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_REG: is_legal = 1'b1;
      default:                           is_legal = 1'b0;
    endcase
  endfunction

  logic [2:0]        state_r, next_state_s;
  logic [1:0]        halt_cause_r, next_cause_s;
  logic              halted_r;
  logic [CNT_W-1:0]  instret_r;
  logic [WAIT_W-1:0] wait_cnt_r, next_wait_s;
  logic              retire_s;

  logic       ir_we_s, ab_we_s, alu_we_s, mdr_we_s, pc_we_s, rf_we_s;
  logic       mem_req_s, mem_we_s, addr_sel_s;
  logic [1:0] pc_src_s, wd_sel_s;

  // Next-state, strobe decode and memory-wait watchdog
  always_comb begin
    next_state_s = state_r;
    next_cause_s = halt_cause_r;
    retire_s     = 1'b0;
    ir_we_s      = 1'b0;
    ab_we_s      = 1'b0;
    alu_we_s     = 1'b0;
    mdr_we_s     = 1'b0;
    pc_we_s      = 1'b0;
    pc_src_s     = 2'b00;
    rf_we_s      = 1'b0;
    wd_sel_s     = 2'b00;
    mem_req_s    = 1'b0;
    mem_we_s     = 1'b0;
    addr_sel_s   = 1'b0;
    next_wait_s  = '0;

    case (state_r)
      S_FETCH: begin
        mem_req_s = 1'b1;
        ir_we_s   = bus.mem_ready;
        if (bus.mem_ready) begin
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        ab_we_s = 1'b1;
        if (is_legal(bus.opcode)) begin
          next_state_s = S_EXEC;
        end else begin
          next_state_s = S_HALT;
          next_cause_s = 2'b01;
        end
      end
      S_EXEC: begin
        alu_we_s = 1'b1;
        if (bus.opcode == OP_LOAD || bus.opcode == OP_STORE) begin
          next_state_s = S_MEM;
        end else if (bus.opcode == OP_BRANCH) begin
          pc_we_s      = 1'b1;
          pc_src_s     = bus.br_taken ? 2'b01 : 2'b00;
          retire_s     = 1'b1;
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_WB;
        end
      end
      S_MEM: begin
        mem_req_s  = 1'b1;
        addr_sel_s = 1'b1;
        mem_we_s   = (bus.opcode == OP_STORE);
        if (!bus.mem_ready) begin
          next_state_s = S_MEM;
        end else if (bus.opcode == OP_STORE) begin
          pc_we_s      = 1'b1;
          retire_s     = 1'b1;
          next_state_s = S_FETCH;
        end else begin
          mdr_we_s     = 1'b1;
          next_state_s = S_WB;
        end
      end
      S_WB: begin
        rf_we_s      = 1'b1;
        pc_we_s      = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
        // wd_sel=10 writes pc+4 from the PC that is only replaced at this same edge
        case (bus.opcode)
          OP_LOAD: wd_sel_s = 2'b01;
          OP_JAL: begin
            wd_sel_s = 2'b10;
            pc_src_s = 2'b01;
          end
          OP_JALR: begin
            wd_sel_s = 2'b10;
            pc_src_s = 2'b10;
          end
          default: wd_sel_s = 2'b00;
        endcase
      end
      S_HALT: next_state_s = S_HALT;
      default: next_state_s = S_HALT;
    endcase

    // A stall only counts while a request is outstanding; ready always wins the last cycle
    if (mem_req_s && !bus.mem_ready) begin
      next_wait_s = wait_cnt_r + 1'b1;
      if (MEM_TIMEOUT != 0 && wait_cnt_r == WAIT_LAST) begin
        next_state_s = S_HALT;
        next_cause_s = 2'b10;
      end else begin
        next_cause_s = next_cause_s;
      end
    end else begin
      next_wait_s = '0;
    end
  end

  // State, watchdog, halt and retired-instruction registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= S_FETCH;
      halt_cause_r <= 2'b00;
      halted_r     <= 1'b0;
      wait_cnt_r   <= '0;
      instret_r    <= '0;
    end else begin
      state_r      <= next_state_s;
      halt_cause_r <= next_cause_s;
      halted_r     <= (next_state_s == S_HALT);
      wait_cnt_r   <= next_wait_s;
      if (retire_s) begin
        instret_r <= instret_r + 1'b1;
      end else begin
        instret_r <= instret_r;
      end
    end
  end

  assign bus.ir_we      = ir_we_s & ~reset;
  assign bus.ab_we      = ab_we_s & ~reset;
  assign bus.alu_we     = alu_we_s & ~reset;
  assign bus.mdr_we     = mdr_we_s & ~reset;
  assign bus.pc_we      = pc_we_s & ~reset;
  assign bus.pc_src     = pc_src_s & {2{~reset}};
  assign bus.rf_we      = rf_we_s & ~reset;
  assign bus.wd_sel     = wd_sel_s & {2{~reset}};
  assign bus.mem_req    = mem_req_s & ~reset;
  assign bus.mem_we     = mem_we_s & ~reset;
  assign bus.addr_sel   = addr_sel_s & ~reset;
  assign bus.halted     = halted_r;
  assign bus.halt_cause = halt_cause_r;
  assign bus.instret    = instret_r;
  assign bus.state      = state_r;

endmodule

// File: tb/tb_xgriscv_mc_ctrl.sv
// Directed bench for xgriscv_mc_ctrl: a per-cycle vector table plus hand-written
// sequences for halt, watchdog and asynchronous reset.
module tb_xgriscv_mc_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  xgriscv_mc_ctrl_if #(.CNT_W(32)) bus ();

  xgriscv_mc_ctrl #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct {
    logic [6:0]  op;
    logic        br;
    logic        rdy;
    logic [2:0]  st;
    logic [12:0] stb;
    logic [1:0]  cause;
    logic [31:0] ir;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // {ir_we, ab_we, alu_we, mdr_we, pc_we, pc_src, rf_we, wd_sel, mem_req, mem_we, addr_sel}
  logic [12:0] stb_s;
  assign stb_s = {bus.ir_we, bus.ab_we, bus.alu_we, bus.mdr_we, bus.pc_we, bus.pc_src,
                  bus.rf_we, bus.wd_sel, bus.mem_req, bus.mem_we, bus.addr_sel};

  function automatic logic [12:0] mk(input logic ir, input logic ab, input logic alu,
                                     input logic mdr, input logic pcw, input logic [1:0] pcs,
                                     input logic rf, input logic [1:0] wd, input logic rq,
                                     input logic we, input logic as);
    return {ir, ab, alu, mdr, pcw, pcs, rf, wd, rq, we, as};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic br, input logic rdy);
    bus.opcode    = op;
    bus.br_taken  = br;
    bus.mem_ready = rdy;
  endtask

  task automatic add(input logic [6:0] op, input logic br, input logic rdy, input logic [2:0] st,
                     input logic [12:0] stb, input logic [1:0] cause, input logic [31:0] ir);
    vec_t v;
    v.op = op; v.br = br; v.rdy = rdy; v.st = st; v.stb = stb; v.cause = cause; v.ir = ir;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(7'b0010011, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    check("reset state", {29'd0, bus.state}, 32'd0);
    check("reset strobes", {19'd0, stb_s}, 32'd0);
    check("reset instret", bus.instret, 32'd0);
    check("reset halted", {31'd0, bus.halted}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] BAD  = 7'b1111111;

  initial begin
    logic [12:0] s_f1, s_f0, s_d, s_e, s_wb, s_wb_ld, s_wb_jalr, s_wb_jal;
    logic [12:0] s_e_bt, s_e_bn, s_m0_ld, s_m1_ld, s_m1_st, s_zero;
    s_f1      = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    s_f0      = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    s_d       = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    s_e       = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    s_wb      = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    s_wb_ld   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    s_wb_jalr = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    s_wb_jal  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    s_e_bt    = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    s_e_bn    = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    s_m0_ld   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
    s_m1_ld   = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
    s_m1_st   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);
    s_zero    = 13'd0;

    // ADDI then ADD, zero-wait memory
    add(ADDI, 1'b0, 1'b1, 3'd0, s_f1, 2'b00, 32'd0);
    add(ADDI, 1'b0, 1'b1, 3'd1, s_d,  2'b00, 32'd0);
    add(ADDI, 1'b0, 1'b1, 3'd2, s_e,  2'b00, 32'd0);
    add(ADDI, 1'b0, 1'b1, 3'd4, s_wb, 2'b00, 32'd0);
    add(ADD,  1'b0, 1'b1, 3'd0, s_f1, 2'b00, 32'd1);
    add(ADD,  1'b0, 1'b1, 3'd1, s_d,  2'b00, 32'd1);
    add(ADD,  1'b0, 1'b1, 3'd2, s_e,  2'b00, 32'd1);
    add(ADD,  1'b0, 1'b1, 3'd4, s_wb, 2'b00, 32'd1);
    // LW with three stall cycles in MEM
    add(LW, 1'b0, 1'b1, 3'd0, s_f1,    2'b00, 32'd2);
    add(LW, 1'b0, 1'b1, 3'd1, s_d,     2'b00, 32'd2);
    add(LW, 1'b0, 1'b1, 3'd2, s_e,     2'b00, 32'd2);
    add(LW, 1'b0, 1'b0, 3'd3, s_m0_ld, 2'b00, 32'd2);
    add(LW, 1'b0, 1'b0, 3'd3, s_m0_ld, 2'b00, 32'd2);
    add(LW, 1'b0, 1'b0, 3'd3, s_m0_ld, 2'b00, 32'd2);
    add(LW, 1'b0, 1'b1, 3'd3, s_m1_ld, 2'b00, 32'd2);
    add(LW, 1'b0, 1'b1, 3'd4, s_wb_ld, 2'b00, 32'd2);
    // BEQ taken, then BEQ not taken
    add(BEQ, 1'b1, 1'b1, 3'd0, s_f1,   2'b00, 32'd3);
    add(BEQ, 1'b1, 1'b1, 3'd1, s_d,    2'b00, 32'd3);
    add(BEQ, 1'b1, 1'b1, 3'd2, s_e_bt, 2'b00, 32'd3);
    add(BEQ, 1'b0, 1'b1, 3'd0, s_f1,   2'b00, 32'd4);
    add(BEQ, 1'b0, 1'b1, 3'd1, s_d,    2'b00, 32'd4);
    add(BEQ, 1'b0, 1'b1, 3'd2, s_e_bn, 2'b00, 32'd4);
    // JALR, JAL
    add(JALR, 1'b0, 1'b1, 3'd0, s_f1,      2'b00, 32'd5);
    add(JALR, 1'b0, 1'b1, 3'd1, s_d,       2'b00, 32'd5);
    add(JALR, 1'b0, 1'b1, 3'd2, s_e,       2'b00, 32'd5);
    add(JALR, 1'b0, 1'b1, 3'd4, s_wb_jalr, 2'b00, 32'd5);
    add(JAL,  1'b0, 1'b1, 3'd0, s_f1,      2'b00, 32'd6);
    add(JAL,  1'b0, 1'b1, 3'd1, s_d,       2'b00, 32'd6);
    add(JAL,  1'b0, 1'b1, 3'd2, s_e,       2'b00, 32'd6);
    add(JAL,  1'b0, 1'b1, 3'd4, s_wb_jal,  2'b00, 32'd6);
    // SW with one fetch stall
    add(SW, 1'b0, 1'b0, 3'd0, s_f0,    2'b00, 32'd7);
    add(SW, 1'b0, 1'b1, 3'd0, s_f1,    2'b00, 32'd7);
    add(SW, 1'b0, 1'b1, 3'd1, s_d,     2'b00, 32'd7);
    add(SW, 1'b0, 1'b1, 3'd2, s_e,     2'b00, 32'd7);
    add(SW, 1'b0, 1'b1, 3'd3, s_m1_st, 2'b00, 32'd7);
    // Illegal opcode
    add(BAD, 1'b0, 1'b1, 3'd0, s_f1,   2'b00, 32'd8);
    add(BAD, 1'b0, 1'b1, 3'd1, s_d,    2'b00, 32'd8);
    add(BAD, 1'b0, 1'b1, 3'd7, s_zero, 2'b01, 32'd8);

    do_reset();
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].br, vecs[i].rdy);
      #1;
      check($sformatf("v%0d state", i), {29'd0, bus.state}, {29'd0, vecs[i].st});
      check($sformatf("v%0d strobes", i), {19'd0, stb_s}, {19'd0, vecs[i].stb});
      check($sformatf("v%0d instret", i), bus.instret, vecs[i].ir);
      check($sformatf("v%0d cause", i), {30'd0, bus.halt_cause}, {30'd0, vecs[i].cause});
      check($sformatf("v%0d halted", i), {31'd0, bus.halted}, {31'd0, (vecs[i].cause != 2'b00)});
      @(negedge clk);
    end

    // HALT is sticky: 20 more cycles with toggling inputs
    for (int k = 0; k < 20; k++) begin
      drive(BAD, k[0], ~k[0]);
      #1;
      check($sformatf("halt%0d state", k), {29'd0, bus.state}, 32'd7);
      check($sformatf("halt%0d strobes", k), {19'd0, stb_s}, 32'd0);
      check($sformatf("halt%0d instret", k), bus.instret, 32'd8);
      @(negedge clk);
    end

    // Watchdog: 15 consecutive fetch stalls halt with cause 10
    do_reset();
    drive(ADDI, 1'b0, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      #1;
      check($sformatf("wd stall%0d state", k), {29'd0, bus.state}, 32'd0);
      @(negedge clk);
    end
    #1;
    check("wd state", {29'd0, bus.state}, 32'd7);
    check("wd cause", {30'd0, bus.halt_cause}, 32'd2);
    check("wd halted", {31'd0, bus.halted}, 32'd1);
    check("wd strobes", {19'd0, stb_s}, 32'd0);
    @(negedge clk);

    // Watchdog boundary: ready arriving on the 15th stall cycle wins
    do_reset();
    drive(ADDI, 1'b0, 1'b0);
    repeat (14) @(negedge clk);
    drive(ADDI, 1'b0, 1'b1);
    #1;
    check("wd edge ir_we", {31'd0, bus.ir_we}, 32'd1);
    @(negedge clk);
    #1;
    check("wd edge state", {29'd0, bus.state}, 32'd1);
    check("wd edge halted", {31'd0, bus.halted}, 32'd0);
    @(negedge clk);

    // Asynchronous reset in the middle of a stalled MEM
    do_reset();
    drive(ADDI, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    drive(LW, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    drive(LW, 1'b0, 1'b0);
    #1;
    check("mid state before", {29'd0, bus.state}, 32'd3);
    check("mid instret before", bus.instret, 32'd1);
    reset = 1'b1;
    #1;
    check("mid reset state", {29'd0, bus.state}, 32'd0);
    check("mid reset instret", bus.instret, 32'd0);
    check("mid reset mem_req", {31'd0, bus.mem_req}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
